// File: rtl/prog_even_divisor.sv
// prog_even_divisor: 50% duty clock divider by 2*H, H reloadable at output rising edges, plus free-running /2 and /4 taps
module prog_even_divisor #(
    parameter int CNT_W    = 8,
    parameter int DEF_HALF = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [CNT_W-1:0] half_i,
    input  logic             load_i,
    output logic             busy_o,
    output logic             load_ack_o,
    output logic             clk_div2,
    output logic             clk_div4,
    output logic             clk_div_p,
    output logic             tick_o
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt, act_h, pend_h;
    logic             wrap, rise, apply;

    // H=0 has no boundary, so a pending value is taken on the very next edge
    always_comb begin
        wrap  = act_h != '0 && en && cnt == act_h - ONE;
        rise  = wrap && !clk_div_p;
        apply = busy_o && (act_h == '0 || rise);
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            clk_div2   <= 1'b0;
            clk_div4   <= 1'b0;
            clk_div_p  <= 1'b0;
            tick_o     <= 1'b0;
            load_ack_o <= 1'b0;
            busy_o     <= 1'b0;
            cnt        <= '0;
            act_h      <= CNT_W'(DEF_HALF);
            pend_h     <= '0;
        end else begin
            clk_div2   <= ~clk_div2;
            if (clk_div2) clk_div4 <= ~clk_div4;
            tick_o     <= rise;
            load_ack_o <= apply;
            busy_o     <= apply ? load_i : busy_o | load_i;
            if (load_i) pend_h <= half_i;
            if (apply) act_h <= pend_h;
            if (act_h == '0) begin
                cnt       <= '0;
                clk_div_p <= 1'b0;
            end else if (en) begin
                cnt <= wrap ? '0 : cnt + ONE;
                if (wrap) clk_div_p <= ~clk_div_p;
            end
        end
    end
endmodule

// File: tb/tb_prog_even_divisor.sv
// tb_prog_even_divisor: directed and random checks of prog_even_divisor against a phase-length model
module tb_prog_even_divisor;
    localparam int CNT_W    = 8;
    localparam int DEF_HALF = 5;

    logic             clk = 1'b0;
    logic             rstn = 1'b1;
    logic             en = 1'b0;
    logic             load_i = 1'b0;
    logic [CNT_W-1:0] half_i = '0;
    logic             busy_o, load_ack_o, clk_div2, clk_div4, clk_div_p, tick_o;

    prog_even_divisor #(.CNT_W(CNT_W), .DEF_HALF(DEF_HALF)) dut (
        .clk(clk), .rstn(rstn), .en(en), .half_i(half_i), .load_i(load_i),
        .busy_o(busy_o), .load_ack_o(load_ack_o), .clk_div2(clk_div2),
        .clk_div4(clk_div4), .clk_div_p(clk_div_p), .tick_o(tick_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // model: edges since release, active/pending H, level and edges left in current phase
    int n, m_h, m_pend, m_rem;
    bit m_busy, m_p, m_tick, m_ack;

    task automatic cmp(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        cmp("clk_div2", clk_div2, 1'(n % 2));
        cmp("clk_div4", clk_div4, 1'((n / 2) % 2));
        cmp("clk_div_p", clk_div_p, m_p);
        cmp("tick_o", tick_o, m_tick);
        cmp("load_ack_o", load_ack_o, m_ack);
        cmp("busy_o", busy_o, m_busy);
    endtask

    task automatic model_reset();
        n = 0; m_h = DEF_HALF; m_pend = 0; m_rem = DEF_HALF;
        m_busy = 0; m_p = 0; m_tick = 0; m_ack = 0;
    endtask

    task automatic model_edge();
        bit applied;
        applied = 0;
        n++;
        m_tick = 0;
        m_ack = 0;
        if (m_h == 0) begin
            m_p = 0;
            if (m_busy) begin m_h = m_pend; m_ack = 1; applied = 1; end
            m_rem = m_h;
        end else if (en) begin
            m_rem--;
            if (m_rem == 0) begin
                if (!m_p) begin
                    m_tick = 1;
                    if (m_busy) begin m_h = m_pend; m_ack = 1; applied = 1; end
                end
                m_p = !m_p;
                m_rem = m_h;
            end
        end
        m_busy = applied ? load_i : (m_busy | load_i);
        if (load_i) m_pend = int'(half_i);
    endtask

    task automatic step(input bit e, input bit l, input int h);
        @(negedge clk);
        en = e; load_i = l; half_i = CNT_W'(h);
        @(posedge clk);
        model_edge();
        #1 check_all();
    endtask

    task automatic run(input int k, input bit e);
        for (int i = 0; i < k; i++) step(e, 1'b0, 0);
    endtask

    initial begin
        int acks;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_all();
        #1 rstn = 1'b0;

        for (int i = 1; i <= 10; i++) begin
            step(1, 0, 0);
            if (i == 5) begin cmp("rise_edge5", clk_div_p, 1'b1); cmp("tick_edge5", tick_o, 1'b1); end
            if (i == 10) cmp("fall_edge10", clk_div_p, 1'b0);
        end

        run(17, 1);
        step(1, 1, 3);
        cmp("busy_after_load3", busy_o, 1'b1);
        run(40, 1);

        acks = 0;
        step(1, 1, 7); acks += int'(load_ack_o);
        step(1, 1, 2); acks += int'(load_ack_o);
        for (int i = 0; i < 30; i++) begin step(1, 0, 0); acks += int'(load_ack_o); end
        cmp("single_ack_two_loads", 1'(acks == 1), 1'b1);

        step(1, 1, 0);
        run(20, 1);
        cmp("stopped_low", clk_div_p, 1'b0);
        step(1, 1, 1);
        step(1, 0, 0);
        cmp("ack_h1_next_edge", load_ack_o, 1'b1);
        run(8, 1);

        step(1, 1, 3);
        run(20, 1);
        for (int i = 0; i < 7; i++) begin
            step(0, i == 3, 4);
            cmp("tick_frozen", tick_o, 1'b0);
        end
        run(30, 1);

        step(1, 1, 4);
        #1 rstn = 1'b1;
        #1 model_reset();
        check_all();
        @(posedge clk);
        #1 check_all();
        #1 rstn = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 0);
            if (i == 4) cmp("no_rise_edge4", clk_div_p, 1'b0);
            if (i == 5) cmp("rise_after_reset", clk_div_p, 1'b1);
        end

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 19) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 6));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/prog_even_divisor.md
Name: prog_even_divisor

Overview:
- Parametrised successor to the fixed even-ratio clock divider: the ratio is runtime-programmable by half-period count H, so divide-by = 2·H.
- Output is 50 % duty, and reprogramming is glitch-free: a new ratio takes effect only at a rising-edge boundary of the divided output.
- Keeps the free-running ÷2 / ÷4 taps of the earlier divider, plus an enable and a load handshake.
- Sits in the clock-generation area; every output is a flop output in the clk domain (no ripple clocking).

Parameters:
- CNT_W, 8, width of the half-period count H and of the internal counter; max divide-by = 2·(2^CNT_W − 1).
- DEF_HALF, 5, H loaded at reset (divide-by-10 after reset); must be 1..2^CNT_W−1.

Ports:
- clk  in  1  reference clock; all state on its rising edge.
- rstn  in  1  asynchronous reset, ACTIVE-HIGH (asserted when 1). The name is kept for family port compatibility; polarity and synchronicity are fixed.
- en  in  1  1 = programmable divider runs; 0 = programmable counter and output frozen.
- half_i  in  CNT_W  requested half-period count H.
- load_i  in  1  single-cycle strobe; captures half_i into the pending register.
- busy_o  out  1  pending value not yet applied.
- load_ack_o  out  1  1-cycle pulse in the cycle a pending value becomes active.
- clk_div2  out  1  free-running clk/2.
- clk_div4  out  1  free-running clk/4.
- clk_div_p  out  1  programmable clk/(2·H).
- tick_o  out  1  1-cycle pulse coincident with each 0→1 transition of clk_div_p.

Behaviour:
- Reset (rstn=1, async):
  - clk_div2=clk_div4=clk_div_p=0; tick_o=load_ack_o=busy_o=0.
  - Counter cnt=0; active H=DEF_HALF; pending register cleared.
- ÷2 / ÷4 taps:
  - clk_div2 toggles on every clk edge after reset release.
  - clk_div4 toggles on edges where clk_div2 is currently 1.
  - Both ignore en and loads.
- Programmable path, en=1, H≥1:
  - If cnt==H−1: cnt←0 and clk_div_p toggles. Otherwise cnt←cnt+1.
  - First clk_div_p rise occurs on the H-th edge after reset release; the output then toggles every H edges.
  - tick_o=1 in the cycle after the edge where clk_div_p went 0→1, i.e. tick_o is registered together with the toggle.
- Load handshake:
  - load_i=1 captures half_i into pending; busy_o=1 from the next cycle.
  - load_i while busy_o=1 overwrites pending (last write wins), with no extra ack.
- Apply point: the edge where clk_div_p toggles 0→1.
  - On that edge, active H←pending; cnt restarts at 0 under the new H; busy_o←0; load_ack_o pulses.
  - The high phase that starts there, and every later phase, uses the new H. No phase is shortened or lengthened: no runt pulses.
- load_i on the apply edge itself: the old pending value is applied, and the new value becomes pending (busy_o stays 1).
- H=0 (stop):
  - When applied, clk_div_p is forced 0 on the next edge, cnt=0, and tick_o stays 0.
  - While active H=0 there is no boundary, so a pending value is applied on the next edge: load_ack_o pulses, and counting starts from cnt=0 with clk_div_p=0.
- en=0:
  - cnt, clk_div_p and active H are held; tick_o=0.
  - Loads are still captured, but only applied at a boundary reached after en returns to 1.
  - Exception: if active H=0, a pending value is applied regardless of en.
- Width rule: H is unsigned CNT_W bits; cnt never exceeds H−1.
- Async reset mid-period or mid-load: immediate return to reset values, and the pending value is discarded.

Test Plan:
- Reset release with defaults, en=1 → clk_div_p rises on edge 5, falls on edge 10, period 10 clk. tick_o pulses every 10 clk. clk_div2 has period 2 and clk_div4 period 4; all outputs stay 0 while rstn=1.
- Load half_i=3 mid high-phase of the ÷10 output → current high and low phases each stay 5 clk. busy_o=1 until the next rise; load_ack_o pulses there. Period is 6 from then on.
- Two loads (7, then 2) before a boundary → only 2 is applied; single load_ack_o; period becomes 4.
- Load half_i=0 → after the next rise, clk_div_p goes low and stays low, with no tick_o. Then load 1 → ack next edge, and clk_div_p toggles every clk (÷2).
- en=0 for 7 clk mid low-phase → clk_div_p and cnt frozen; low phase extended by exactly 7 clk; clk_div2/clk_div4 unaffected.
- Assert rstn for 1 clk mid-period with busy_o=1 → all outputs 0 immediately, pending value lost, H=5 restored, and the first rise comes 5 edges after release.
